// File: rtl/count_window_monitor.sv
`default_nettype none
// ============================================================================
// Module   : count_window_monitor
// Purpose  : Debounced low/high window classifier and wrap detector for an
//            up/down counter, with sticky flags, event counter and IRQ.
// Revision : 1.0
// ============================================================================
module count_window_monitor #(
    parameter int WIDTH = 8,
    parameter int HOLD  = 4,
    parameter int EVT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] count_in,
    input  logic             up_down,
    input  logic             cfg_valid,
    input  logic [WIDTH-1:0] lo_thr,
    input  logic [WIDTH-1:0] hi_thr,
    input  logic             irq_ack,
    output logic             armed,
    output logic [1:0]       zone,
    output logic             hi_flag,
    output logic             lo_flag,
    output logic             wrap_flag,
    output logic             cfg_err,
    output logic             irq,
    output logic [EVT_W-1:0] evt_count
);

    // State encoding doubles as the zone output code.
    typedef enum logic [1:0] {
        ST_BELOW  = 2'b00,
        ST_INSIDE = 2'b01,
        ST_ABOVE  = 2'b10,
        ST_IDLE   = 2'b11
    } state_t;

    localparam logic [WIDTH-1:0] C_ALL_ONES = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] C_ZERO     = {WIDTH{1'b0}};
    localparam logic [3:0]       C_HOLD     = 4'(HOLD);
    localparam logic [EVT_W-1:0] C_EVT_MAX  = {EVT_W{1'b1}};

    state_t           r_state;
    state_t           w_state_nxt;
    state_t           r_cand;
    state_t           w_cand_nxt;
    state_t           w_raw;
    logic [3:0]       r_run;
    logic [3:0]       w_run_nxt;
    logic [3:0]       w_run_inc;
    logic             w_commit;

    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_s_cnt;
    logic [WIDTH-1:0] r_p_cnt;
    logic             r_s_dir;
    logic             r_armed;
    logic             r_hi_flag;
    logic             r_lo_flag;
    logic             r_wrap_flag;
    logic             r_cfg_err;
    logic             r_irq;
    logic [EVT_W-1:0] r_evt;

    logic             w_cfg_ok;
    logic             w_cfg_bad;
    logic             w_wrap;
    logic             w_hi_evt;
    logic             w_lo_evt;
    logic             w_any_evt;
    logic [1:0]       w_inc;
    logic [EVT_W:0]   w_evt_sum;

    always_comb begin
        w_raw = ST_INSIDE;
        if (r_s_cnt > r_hi) begin
            w_raw = ST_ABOVE;
        end else if (r_s_cnt < r_lo) begin
            w_raw = ST_BELOW;
        end
    end

    assign w_cfg_ok  = cfg_valid && (lo_thr <= hi_thr);
    assign w_cfg_bad = cfg_valid && (lo_thr > hi_thr);
    assign w_wrap    = r_armed &&
                       (( r_s_dir && (r_p_cnt == C_ALL_ONES) && (r_s_cnt == C_ZERO)) ||
                        (!r_s_dir && (r_p_cnt == C_ZERO)     && (r_s_cnt == C_ALL_ONES)));

    // Commit fires on the edge where the run would reach HOLD, so the run
    // register itself never holds HOLD.
    always_comb begin
        w_state_nxt = r_state;
        w_cand_nxt  = r_cand;
        w_run_nxt   = r_run;
        w_run_inc   = 4'd0;
        w_commit    = 1'b0;
        if (r_state == ST_IDLE) begin
            if (w_cfg_ok) begin
                w_state_nxt = ST_INSIDE;
            end
        end else if (w_raw == r_state) begin
            w_run_nxt = 4'd0;
        end else begin
            w_run_inc  = (w_raw == r_cand) ? (r_run + 4'd1) : 4'd1;
            w_cand_nxt = w_raw;
            if (w_run_inc == C_HOLD) begin
                w_state_nxt = w_raw;
                w_run_nxt   = 4'd0;
                w_commit    = 1'b1;
            end else begin
                w_run_nxt = w_run_inc;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_cand  <= ST_BELOW;
            r_run   <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cand  <= w_cand_nxt;
            r_run   <= w_run_nxt;
        end
    end

    assign w_hi_evt  = w_commit && (w_state_nxt == ST_ABOVE);
    assign w_lo_evt  = w_commit && (w_state_nxt == ST_BELOW);
    assign w_any_evt = w_hi_evt | w_lo_evt | w_wrap;
    assign w_inc     = {1'b0, w_hi_evt | w_lo_evt} + {1'b0, w_wrap};
    assign w_evt_sum = {1'b0, r_evt} + {{(EVT_W-1){1'b0}}, w_inc};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_lo        <= C_ZERO;
            r_hi        <= C_ALL_ONES;
            r_s_cnt     <= C_ZERO;
            r_p_cnt     <= C_ZERO;
            r_s_dir     <= 1'b0;
            r_armed     <= 1'b0;
            r_hi_flag   <= 1'b0;
            r_lo_flag   <= 1'b0;
            r_wrap_flag <= 1'b0;
            r_cfg_err   <= 1'b0;
            r_irq       <= 1'b0;
            r_evt       <= {EVT_W{1'b0}};
        end else begin
            r_s_cnt <= count_in;
            r_p_cnt <= r_s_cnt;
            r_s_dir <= up_down;
            if (w_cfg_ok) begin
                r_lo    <= lo_thr;
                r_hi    <= hi_thr;
                r_armed <= 1'b1;
            end
            r_cfg_err <= w_cfg_bad;
            // A new event on the ack edge wins over the clear.
            r_hi_flag   <= w_hi_evt  | (r_hi_flag   & ~irq_ack);
            r_lo_flag   <= w_lo_evt  | (r_lo_flag   & ~irq_ack);
            r_wrap_flag <= w_wrap    | (r_wrap_flag & ~irq_ack);
            r_irq       <= w_any_evt | (r_irq       & ~irq_ack);
            r_evt       <= w_evt_sum[EVT_W] ? C_EVT_MAX : w_evt_sum[EVT_W-1:0];
        end
    end

    assign armed     = r_armed;
    assign zone      = r_state;
    assign hi_flag   = r_hi_flag;
    assign lo_flag   = r_lo_flag;
    assign wrap_flag = r_wrap_flag;
    assign cfg_err   = r_cfg_err;
    assign irq       = r_irq;
    assign evt_count = r_evt;

endmodule
`default_nettype wire

// File: tb/tb_count_window_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_count_window_monitor
// Purpose  : Directed scenarios plus randomized run against a queue-based model.
// Revision : 1.0
// ============================================================================
module tb_count_window_monitor;

    localparam int WIDTH = 8;
    localparam int HOLD  = 4;
    localparam int EVT_W = 8;

    logic             clk = 1'b0;
    logic             reset;
    logic [WIDTH-1:0] count_in;
    logic             up_down;
    logic             cfg_valid;
    logic [WIDTH-1:0] lo_thr;
    logic [WIDTH-1:0] hi_thr;
    logic             irq_ack;
    logic             armed;
    logic [1:0]       zone;
    logic             hi_flag;
    logic             lo_flag;
    logic             wrap_flag;
    logic             cfg_err;
    logic             irq;
    logic [EVT_W-1:0] evt_count;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    count_window_monitor #(
        .WIDTH (WIDTH),
        .HOLD  (HOLD),
        .EVT_W (EVT_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .count_in  (count_in),
        .up_down   (up_down),
        .cfg_valid (cfg_valid),
        .lo_thr    (lo_thr),
        .hi_thr    (hi_thr),
        .irq_ack   (irq_ack),
        .armed     (armed),
        .zone      (zone),
        .hi_flag   (hi_flag),
        .lo_flag   (lo_flag),
        .wrap_flag (wrap_flag),
        .cfg_err   (cfg_err),
        .irq       (irq),
        .evt_count (evt_count)
    );

    // Reference model: zone history kept as a queue of the last HOLD raw zones.
    logic [1:0] m_zone;
    logic       m_armed, m_hi, m_lo, m_wrap, m_cerr, m_irq, m_dir;
    logic [7:0] m_evt, m_lo_t, m_hi_t, m_s, m_p;
    logic [1:0] m_hist[$];

    function automatic logic [1:0] classify(input logic [7:0] v, input logic [7:0] lo, input logic [7:0] hi);
        if (v > hi) return 2'b10;
        if (v < lo) return 2'b00;
        return 2'b01;
    endfunction

    task automatic model_reset();
        m_zone = 2'b11; m_armed = 0; m_hi = 0; m_lo = 0; m_wrap = 0; m_cerr = 0; m_irq = 0;
        m_dir = 0; m_evt = 0; m_lo_t = 8'd0; m_hi_t = 8'hFF; m_s = 0; m_p = 0;
        m_hist.delete();
    endtask

    task automatic model_edge();
        logic [1:0] raw, nz;
        logic       wrap, zh, zl, same;
        int         n;
        raw  = classify(m_s, m_lo_t, m_hi_t);
        wrap = m_armed && ((m_dir && m_p == 8'hFF && m_s == 8'h00) ||
                           (!m_dir && m_p == 8'h00 && m_s == 8'hFF));
        nz = m_zone; zh = 0; zl = 0;
        if (m_zone != 2'b11) begin
            m_hist.push_back(raw);
            if (m_hist.size() > HOLD) void'(m_hist.pop_front());
            if (m_hist.size() == HOLD && raw != m_zone) begin
                same = 1'b1;
                foreach (m_hist[i]) if (m_hist[i] != raw) same = 1'b0;
                if (same) begin
                    nz = raw; zh = (raw == 2'b10); zl = (raw == 2'b00);
                end
            end
        end
        m_cerr = 1'b0;
        if (cfg_valid) begin
            if (lo_thr <= hi_thr) begin
                m_lo_t = lo_thr; m_hi_t = hi_thr; m_armed = 1'b1;
                if (m_zone == 2'b11) begin
                    nz = 2'b01; m_hist.delete();
                end
            end else begin
                m_cerr = 1'b1;
            end
        end
        n = int'(zh) + int'(zl) + int'(wrap);
        if (irq_ack) begin m_hi = 0; m_lo = 0; m_wrap = 0; m_irq = 0; end
        if (zh) m_hi = 1'b1;
        if (zl) m_lo = 1'b1;
        if (wrap) m_wrap = 1'b1;
        if (n > 0) m_irq = 1'b1;
        m_evt  = (int'(m_evt) + n > 255) ? 8'hFF : 8'(int'(m_evt) + n);
        m_zone = nz;
        m_p    = m_s;
        m_s    = count_in;
        m_dir  = up_down;
    endtask

    task automatic step(input logic [7:0] c, input logic d, input logic ack);
        count_in = c; up_down = d; irq_ack = ack; cfg_valid = 1'b0;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic cfg_step(input logic [7:0] c, input logic d, input logic [7:0] lo, input logic [7:0] hi);
        count_in = c; up_down = d; irq_ack = 1'b0; cfg_valid = 1'b1; lo_thr = lo; hi_thr = hi;
        @(posedge clk);
        model_edge();
        #1;
        cfg_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0; count_in = 0; up_down = 0; cfg_valid = 0; lo_thr = 0; hi_thr = 0; irq_ack = 0;
        model_reset();
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        checks++;
        if ({zone, armed, hi_flag, lo_flag, wrap_flag, cfg_err, irq} !== 8'b11_000000) begin
            failures++;
            $display("FAIL reset_ctrl: got %b expected %b", {zone, armed, hi_flag, lo_flag, wrap_flag, cfg_err, irq}, 8'b11_000000);
        end
        checks++;
        if (evt_count !== 8'd0) begin
            failures++;
            $display("FAIL reset_evt: got %0d expected 0", evt_count);
        end
    endtask

    task automatic test_unconfigured();
        logic [7:0] seq [4] = '{8'd254, 8'd255, 8'd0, 8'd1};
        foreach (seq[i]) begin
            step(seq[i], 1'b1, 1'b0);
            checks++;
            if ({zone, irq, wrap_flag, evt_count} !== {2'b11, 2'b00, 8'd0}) begin
                failures++;
                $display("FAIL unconfigured_%0d: got %h expected %h", i, {zone, irq, wrap_flag, evt_count}, {2'b11, 2'b00, 8'd0});
            end
        end
        cfg_step(8'd1, 1'b1, 8'd30, 8'd5);
        checks++;
        if ({cfg_err, armed, zone} !== 4'b1011) begin
            failures++;
            $display("FAIL cfg_err_pulse: got %b expected 1011", {cfg_err, armed, zone});
        end
        step(8'd2, 1'b1, 1'b0);
        checks++;
        if ({cfg_err, armed, zone} !== 4'b0011) begin
            failures++;
            $display("FAIL cfg_err_clear: got %b expected 0011", {cfg_err, armed, zone});
        end
    endtask

    task automatic test_window();
        cfg_step(8'd0, 1'b1, 8'd10, 8'd20);
        checks++;
        if ({zone, armed, cfg_err} !== 4'b0110) begin
            failures++;
            $display("FAIL cfg_accept: got %b expected 0110", {zone, armed, cfg_err});
        end
        for (int v = 1; v <= 3; v++) step(8'(v), 1'b1, 1'b0);
        checks++;
        if (zone !== 2'b01) begin
            failures++;
            $display("FAIL below_early: got %b expected 01", zone);
        end
        step(8'd4, 1'b1, 1'b0);
        checks++;
        if ({zone, lo_flag, irq, evt_count} !== {2'b00, 2'b11, 8'd1}) begin
            failures++;
            $display("FAIL below_commit: got %h expected %h", {zone, lo_flag, irq, evt_count}, {2'b00, 2'b11, 8'd1});
        end
        for (int v = 5; v <= 13; v++) step(8'(v), 1'b1, 1'b0);
        checks++;
        if (zone !== 2'b00) begin
            failures++;
            $display("FAIL inside_early: got %b expected 00", zone);
        end
        step(8'd14, 1'b1, 1'b0);
        checks++;
        if ({zone, evt_count} !== {2'b01, 8'd1}) begin
            failures++;
            $display("FAIL inside_commit: got %h expected %h", {zone, evt_count}, {2'b01, 8'd1});
        end
        for (int v = 15; v <= 20; v++) step(8'(v), 1'b1, 1'b0);
        for (int k = 0; k < 4; k++) step(8'd21, 1'b1, 1'b0);
        checks++;
        if (zone !== 2'b01) begin
            failures++;
            $display("FAIL above_early: got %b expected 01", zone);
        end
        step(8'd21, 1'b1, 1'b0);
        checks++;
        if ({zone, hi_flag, lo_flag, irq, evt_count} !== {2'b10, 3'b111, 8'd2}) begin
            failures++;
            $display("FAIL above_commit: got %h expected %h", {zone, hi_flag, lo_flag, irq, evt_count}, {2'b10, 3'b111, 8'd2});
        end
    endtask

    task automatic test_glitch();
        logic [7:0] seq [8] = '{8'd21, 8'd21, 8'd21, 8'd15, 8'd21, 8'd21, 8'd21, 8'd21};
        step(8'd15, 1'b1, 1'b1);
        checks++;
        if ({hi_flag, lo_flag, wrap_flag, irq} !== 4'b0000) begin
            failures++;
            $display("FAIL ack_clear: got %b expected 0000", {hi_flag, lo_flag, wrap_flag, irq});
        end
        for (int k = 0; k < 4; k++) step(8'd15, 1'b1, 1'b0);
        checks++;
        if (zone !== 2'b01) begin
            failures++;
            $display("FAIL glitch_setup: got %b expected 01", zone);
        end
        foreach (seq[i]) begin
            step(seq[i], 1'b1, 1'b0);
            checks++;
            if ({zone, evt_count} !== {2'b01, 8'd2}) begin
                failures++;
                $display("FAIL glitch_hold_%0d: got %h expected %h", i, {zone, evt_count}, {2'b01, 8'd2});
            end
        end
        step(8'd21, 1'b1, 1'b0);
        checks++;
        if ({zone, hi_flag, irq, evt_count} !== {2'b10, 2'b11, 8'd3}) begin
            failures++;
            $display("FAIL glitch_commit: got %h expected %h", {zone, hi_flag, irq, evt_count}, {2'b10, 2'b11, 8'd3});
        end
    endtask

    task automatic test_wrap();
        step(8'd254, 1'b1, 1'b1);
        step(8'd255, 1'b1, 1'b0);
        step(8'd0, 1'b1, 1'b0);
        checks++;
        if ({wrap_flag, irq} !== 2'b00) begin
            failures++;
            $display("FAIL wrap_up_early: got %b expected 00", {wrap_flag, irq});
        end
        step(8'd0, 1'b1, 1'b0);
        checks++;
        if ({wrap_flag, irq, evt_count} !== {2'b11, 8'd4}) begin
            failures++;
            $display("FAIL wrap_up: got %h expected %h", {wrap_flag, irq, evt_count}, {2'b11, 8'd4});
        end
        step(8'd1, 1'b0, 1'b1);
        checks++;
        if ({hi_flag, lo_flag, wrap_flag, irq} !== 4'b0000) begin
            failures++;
            $display("FAIL wrap_ack: got %b expected 0000", {hi_flag, lo_flag, wrap_flag, irq});
        end
        step(8'd0, 1'b0, 1'b0);
        step(8'd255, 1'b0, 1'b0);
        checks++;
        if (wrap_flag !== 1'b0) begin
            failures++;
            $display("FAIL wrap_dn_early: got %b expected 0", wrap_flag);
        end
        step(8'd255, 1'b0, 1'b0);
        checks++;
        if ({wrap_flag, lo_flag, irq, evt_count} !== {3'b111, 8'd6}) begin
            failures++;
            $display("FAIL wrap_dn: got %h expected %h", {wrap_flag, lo_flag, irq, evt_count}, {3'b111, 8'd6});
        end
    endtask

    task automatic test_ack_collision();
        step(8'd255, 1'b0, 1'b0);
        step(8'd255, 1'b0, 1'b1);
        step(8'd255, 1'b0, 1'b0);
        checks++;
        if ({zone, hi_flag, lo_flag, evt_count} !== {2'b10, 2'b10, 8'd7}) begin
            failures++;
            $display("FAIL coll_setup_hi: got %h expected %h", {zone, hi_flag, lo_flag, evt_count}, {2'b10, 2'b10, 8'd7});
        end
        step(8'd0, 1'b1, 1'b0);
        step(8'd0, 1'b1, 1'b0);
        step(8'd0, 1'b1, 1'b0);
        step(8'd0, 1'b1, 1'b0);
        checks++;
        if ({hi_flag, lo_flag, wrap_flag, evt_count} !== {3'b101, 8'd8}) begin
            failures++;
            $display("FAIL coll_setup_wrap: got %h expected %h", {hi_flag, lo_flag, wrap_flag, evt_count}, {3'b101, 8'd8});
        end
        step(8'd0, 1'b1, 1'b1);
        checks++;
        if ({zone, irq, hi_flag, lo_flag, wrap_flag, evt_count} !== {2'b00, 4'b1010, 8'd9}) begin
            failures++;
            $display("FAIL ack_collision: got %h expected %h", {zone, irq, hi_flag, lo_flag, wrap_flag, evt_count}, {2'b00, 4'b1010, 8'd9});
        end
    endtask

    task automatic test_saturate();
        for (int i = 0; i < 304; i++) begin
            if (i % 2 == 0) step(8'd255, 1'b0, 1'b0);
            else            step(8'd0, 1'b1, 1'b0);
            if (i == 100) begin
                checks++;
                if (evt_count !== 8'd109) begin
                    failures++;
                    $display("FAIL evt_mid: got %0d expected 109", evt_count);
                end
            end
            if (i == 299 || i == 303) begin
                checks++;
                if ({wrap_flag, evt_count} !== {1'b1, 8'hFF}) begin
                    failures++;
                    $display("FAIL evt_saturate_%0d: got %h expected %h", i, {wrap_flag, evt_count}, {1'b1, 8'hFF});
                end
            end
        end
    endtask

    task automatic test_async_reset();
        step(8'd200, 1'b1, 1'b0);
        step(8'd200, 1'b1, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if ({zone, armed, hi_flag, lo_flag, wrap_flag, cfg_err, irq, evt_count} !== {8'b11_000000, 8'd0}) begin
            failures++;
            $display("FAIL async_reset: got %h expected %h", {zone, armed, hi_flag, lo_flag, wrap_flag, cfg_err, irq, evt_count}, {8'b11_000000, 8'd0});
        end
        model_reset();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        step(8'd200, 1'b1, 1'b0);
        checks++;
        if ({zone, armed, irq, evt_count} !== {2'b11, 2'b00, 8'd0}) begin
            failures++;
            $display("FAIL post_reset_idle: got %h expected %h", {zone, armed, irq, evt_count}, {2'b11, 2'b00, 8'd0});
        end
    endtask

    task automatic test_random();
        logic [7:0]  c, a, b, t;
        logic        d, ack;
        int          r;
        logic [15:0] obs, exp;
        c = 8'd100; d = 1'b1;
        cfg_step(c, d, 8'd64, 8'd192);
        for (int i = 0; i < 2000; i++) begin
            r   = int'($urandom_range(0, 99));
            ack = ($urandom_range(0, 7) == 0);
            lo_thr = 8'($urandom);
            hi_thr = 8'($urandom);
            if (r < 8) d = ~d;
            if (r < 12)      c = 8'($urandom);
            else if (r < 45) c = c;
            else             c = d ? c + 8'd1 : c - 8'd1;
            if (r < 4) begin
                a = 8'($urandom); b = 8'($urandom);
                if (r < 3 && a > b) begin t = a; a = b; b = t; end
                cfg_step(c, d, a, b);
            end else begin
                step(c, d, ack);
            end
            obs = {zone, armed, hi_flag, lo_flag, wrap_flag, cfg_err, irq, evt_count};
            exp = {m_zone, m_armed, m_hi, m_lo, m_wrap, m_cerr, m_irq, m_evt};
            checks++;
            if (obs !== exp) begin
                failures++;
                $display("FAIL random_%0d: got %h expected %h", i, obs, exp);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        do_reset();
        test_reset();
        test_unconfigured();
        test_window();
        test_glitch();
        test_wrap();
        test_ack_collision();
        test_saturate();
        test_async_reset();
        do_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
